// File: rtl/mire_pkg.sv
// Definitions shared by the mire pattern writer and the VGA framebuffer reader.
package mire_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [15:0] WHITE = 16'hFFFF;
  localparam logic [15:0] BLUE  = 16'h001F;
  localparam logic [15:0] RED   = 16'hF800;

  // Byte address of pixel (x,y); the reader uses this too so both agree on the layout.
  function automatic logic [31:0] pixel_addr(input logic [31:0] base,
                                             input logic [31:0] hdisp,
                                             input logic [31:0] x,
                                             input logic [31:0] y);
    return base + 32'd2 * (hdisp * y + x);
  endfunction

endpackage

// File: rtl/mire_if.sv
// Wishbone write-side bus between the pattern generator and the shared arbiter.
interface mire_if;
  logic [31:0] adr;
  logic [15:0] dat_ms;
  logic [1:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;

  modport master (
    output adr, dat_ms, sel, we, cyc, stb, cti, bte,
    input  ack
  );

  modport slave (
    input  adr, dat_ms, sel, we, cyc, stb, cti, bte,
    output ack
  );
endinterface

// File: rtl/mire_pattern.sv
// Combinational RGB565 test-pattern lookup: grid lines every 16 pixels over
// alternating 32-pixel red/blue columns.
module mire_pattern
  import mire_pkg::*;
#(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic [XW-1:0] gx,
  input  logic [YW-1:0] y,
  output logic [15:0]   rgb
);

  // Widened copies so narrow counters (tiny test frames) still have bits 3 and 5.
  logic [15:0] gx_ext;
  logic [15:0] y_ext;

  assign gx_ext = 16'(gx);
  assign y_ext  = 16'(y);

  always_comb begin
    if (gx_ext[3:0] == 4'd0 || y_ext[3:0] == 4'd0) begin
      rgb = WHITE;
    end else if (gx_ext[5]) begin
      rgb = BLUE;
    end else begin
      rgb = RED;
    end
  end

endmodule

// File: rtl/mire_gen.sv
// Wishbone write master filling the framebuffer with a (optionally scrolling)
// test pattern, yielding the bus for one cycle after every BURST_MAX writes.
module mire_gen
  import mire_pkg::*;
#(
  parameter int          HDISP     = 640,
  parameter int          VDISP     = 480,
  parameter logic [31:0] ADDR_BASE = 32'd0,
  parameter int          BURST_MAX = 64,
  parameter int          SCROLL    = 1
) (
  input  logic   CLK,
  input  logic   NRST,
  input  logic   enable,
  output logic   busy,
  output logic   frame_done,
  mire_if.master wshb
);

  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam int BW = $clog2(BURST_MAX);
  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURST_MAX - 1);

  state_t        state_reg, state_next;
  logic [XW-1:0] x_reg, x_next;
  logic [YW-1:0] y_reg, y_next;
  logic [XW-1:0] offset_reg, offset_next;
  logic [BW-1:0] burst_reg, burst_next;

  logic          acked;
  logic          last_pix;
  logic [XW-1:0] gx;
  logic [15:0]   rgb;

  assign acked    = (state_reg == WRITE) && wshb.ack;
  assign last_pix = (x_reg == X_LAST) && (y_reg == Y_LAST);
  assign gx       = x_reg + offset_reg;

  mire_pattern #(.XW(XW), .YW(YW)) u_pattern (
    .gx  (gx),
    .y   (y_reg),
    .rgb (rgb)
  );

  always_comb begin
    state_next  = state_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    offset_next = offset_reg;
    burst_next  = burst_reg;
    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next = WRITE;
          x_next     = '0;
          y_next     = '0;
          burst_next = '0;
        end
      end
      WRITE: begin
        if (wshb.ack) begin
          burst_next = burst_reg + 1'b1;
          if (x_reg == X_LAST) begin
            x_next = '0;
            y_next = y_reg + 1'b1;
          end else begin
            x_next = x_reg + 1'b1;
          end
          // End of frame wins over the burst limit so a frame never ends in PAUSE.
          if (last_pix) begin
            x_next     = '0;
            y_next     = '0;
            burst_next = '0;
            if (SCROLL != 0) begin
              offset_next = offset_reg + 1'b1;
            end
            state_next = enable ? WRITE : IDLE;
          end else if (burst_reg == B_LAST) begin
            burst_next = '0;
            state_next = PAUSE;
          end
        end
      end
      PAUSE:   state_next = WRITE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_reg  <= IDLE;
      x_reg      <= '0;
      y_reg      <= '0;
      offset_reg <= '0;
      burst_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      offset_reg <= offset_next;
      burst_reg  <= burst_next;
    end
  end

  assign busy        = (state_reg != IDLE);
  assign frame_done  = acked && last_pix;
  assign wshb.cyc    = (state_reg == WRITE);
  assign wshb.stb    = (state_reg == WRITE);
  assign wshb.adr    = pixel_addr(ADDR_BASE, 32'(HDISP), 32'(x_reg), 32'(y_reg));
  assign wshb.dat_ms = (state_reg == WRITE) ? rgb : 16'h0000;
  assign wshb.sel    = 2'b11;
  assign wshb.we     = 1'b1;
  assign wshb.cti    = 3'b000;
  assign wshb.bte    = 2'b00;

endmodule

// File: tb/tb_mire_gen.sv
// Bench for mire_gen on a 640x6 frame: pixel scoreboard, burst pauses,
// wait-state stability, enable drop, scrolling and mid-burst reset.
module tb_mire_gen;

  localparam int HDISP     = 640;
  localparam int VDISP     = 6;
  localparam int BURST_MAX = 64;
  localparam int NPIX      = HDISP * VDISP;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic enable = 1'b0;
  logic busy;
  logic frame_done;

  mire_if bus ();

  mire_gen #(
    .HDISP     (HDISP),
    .VDISP     (VDISP),
    .ADDR_BASE (32'd0),
    .BURST_MAX (BURST_MAX),
    .SCROLL    (1)
  ) dut (
    .CLK        (clk),
    .NRST       (nrst),
    .enable     (enable),
    .busy       (busy),
    .frame_done (frame_done),
    .wshb       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          frame;
    int          idx;
    logic [31:0] adr;
    logic [15:0] dat;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Scoreboard state
  int   idx, off, burst, frame_no, wait_left;
  bit   exp_pause, exp_resume, exp_idle, frame_end, hold_valid, ack_random;
  logic [31:0] hold_adr;
  logic [15:0] hold_dat;
  logic [31:0] log_adr [0:1][0:NPIX-1];
  logic [15:0] log_dat [0:1][0:NPIX-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_pix(input int x, input int y, input int o);
    int g;
    g = (x + o) % 1024;
    if ((g % 16) == 0 || (y % 16) == 0) return 16'hFFFF;
    if (((g / 32) % 2) == 1) return 16'h001F;
    return 16'hF800;
  endfunction

  task automatic reset_model();
    idx = 0; off = 0; burst = 0;
    exp_pause = 0; exp_resume = 0; exp_idle = 0;
    frame_end = 0; hold_valid = 0;
  endtask

  // One clock cycle: drive ack at the falling edge, then observe the bus.
  task automatic step();
    @(negedge clk);
    if (ack_random) begin
      if (wait_left == 0) begin
        bus.ack = 1'b1;
        wait_left = $urandom_range(0, 5);
      end else begin
        bus.ack = 1'b0;
        wait_left--;
      end
    end else begin
      bus.ack = 1'b1;
    end
    #1;
    frame_end = 0;
    if (exp_pause) begin
      chk("pause_cyc", bus.cyc, 0);
      chk("pause_busy", busy, 1);
      exp_pause = 0;
      exp_resume = 1;
    end else if (exp_resume) begin
      chk("resume_cyc", bus.cyc, 1);
      chk("resume_stb", bus.stb, 1);
      exp_resume = 0;
    end else if (exp_idle) begin
      chk("idle_cyc", bus.cyc, 0);
      chk("idle_busy", busy, 0);
      exp_idle = 0;
    end
    if (bus.stb && hold_valid) begin
      chk("hold_adr", bus.adr, hold_adr);
      chk("hold_dat", bus.dat_ms, hold_dat);
    end
    hold_valid = 0;
    if (bus.cyc && bus.stb && bus.ack) begin
      chk("wr_adr", bus.adr, 32'(2 * idx));
      chk("wr_dat", bus.dat_ms, model_pix(idx % HDISP, idx / HDISP, off));
      chk("frame_done", frame_done, (idx == NPIX - 1));
      if (frame_no < 2) begin
        log_adr[frame_no][idx] = bus.adr;
        log_dat[frame_no][idx] = bus.dat_ms;
      end
      burst++;
      idx++;
      if (idx == NPIX) begin
        idx = 0;
        burst = 0;
        off = (off + 1) % 1024;
        frame_no++;
        frame_end = 1;
        if (enable) exp_resume = 1;
        else exp_idle = 1;
      end else if (burst == BURST_MAX) begin
        burst = 0;
        exp_pause = 1;
      end
    end else begin
      chk("no_frame_done", frame_done, 0);
      if (bus.stb) begin
        hold_valid = 1;
        hold_adr = bus.adr;
        hold_dat = bus.dat_ms;
      end
    end
  endtask

  task automatic run_frame(input int drop_at);
    int n;
    n = 0;
    do begin
      if (drop_at >= 0 && idx >= drop_at) enable = 1'b0;
      step();
      n++;
    end while (!frame_end && n < 40000);
    checks++;
    if (!frame_end) begin
      errors++;
      $display("FAIL frame_timeout: got no frame end after %0d cycles, required one", n);
    end
    $display("frame %0d ended after %0d cycles", frame_no, n);
  endtask

  initial begin
    vec_t vecs [8];
    int   n;

    vecs[0] = '{0, 0,    32'd0,    16'hFFFF};
    vecs[1] = '{0, 641,  32'd1282, 16'hF800};
    vecs[2] = '{0, 673,  32'd1346, 16'h001F};
    vecs[3] = '{0, 64,   32'd128,  16'hFFFF};
    vecs[4] = '{0, 3839, 32'd7678, 16'h001F};
    vecs[5] = '{1, 655,  32'd1310, 16'hFFFF};
    vecs[6] = '{1, 640,  32'd1280, 16'hF800};
    vecs[7] = '{1, 3839, 32'd7678, 16'hFFFF};

    bus.ack = 1'b0;
    ack_random = 0;
    wait_left = 0;
    frame_no = 0;
    reset_model();

    repeat (3) @(negedge clk);
    #1;
    chk("rst_cyc", bus.cyc, 0);
    chk("rst_stb", bus.stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_adr", bus.adr, 32'd0);
    chk("rst_dat", bus.dat_ms, 16'h0000);
    chk("const_sel", bus.sel, 2'b11);
    chk("const_we", bus.we, 1);
    chk("const_cti", bus.cti, 3'b000);
    chk("const_bte", bus.bte, 2'b00);
    nrst = 1'b1;

    // Idle with ack forced high: nothing may happen.
    step();
    step();
    chk("idle_disabled_cyc", bus.cyc, 0);

    // Frame 0: zero wait states.
    enable = 1'b1;
    step();
    chk("start_busy", busy, 1);
    chk("start_cyc", bus.cyc, 1);
    run_frame(-1);

    // Frame 1: random wait states, scrolled by one.
    ack_random = 1;
    run_frame(-1);
    ack_random = 0;

    for (int i = 0; i < 8; i++) begin
      chk("vec_adr", log_adr[vecs[i].frame][vecs[i].idx], vecs[i].adr);
      chk("vec_dat", 32'(log_dat[vecs[i].frame][vecs[i].idx]), 32'(vecs[i].dat));
      $display("vec %0d: frame %0d pixel %0d adr=%0d dat=%04h", i, vecs[i].frame,
               vecs[i].idx, log_adr[vecs[i].frame][vecs[i].idx],
               log_dat[vecs[i].frame][vecs[i].idx]);
    end

    // Frame 2: enable drops at pixel 1000; frame still completes.
    run_frame(1000);
    step();
    step();
    chk("stay_idle_cyc", bus.cyc, 0);
    chk("stay_idle_busy", busy, 0);

    // Frame 3: restart from pixel 0, then reset in the middle of a burst.
    enable = 1'b1;
    step();
    chk("restart_adr", bus.adr, 32'd0);
    for (int i = 0; i < 100; i++) step();
    n = 0;
    while (!bus.stb && n < 10) begin
      step();
      n++;
    end
    chk("stb_before_rst", bus.stb, 1);
    nrst = 1'b0;
    #1;
    chk("async_rst_cyc", bus.cyc, 0);
    chk("async_rst_stb", bus.stb, 0);
    chk("async_rst_busy", busy, 0);
    reset_model();
    step();
    nrst = 1'b1;
    step();
    chk("post_rst_adr", bus.adr, 32'd0);
    chk("post_rst_dat", bus.dat_ms, 16'hFFFF);
    run_frame(-1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
